// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment display controller.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;

    // Active-low segment patterns, {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4-digit BCD, one conversion every 17 clocks.
// bcd is the live shift-register view; it is only meaningful while done is high.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int BIN_W = 14;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam logic [3:0] LAST_SHIFT = 4'(BIN_W - 1);

    conv_state_t     state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [3:0]      cnt;

    function automatic logic [SR_W-1:0] dabble_adj(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[BIN_W + 4*i +: 4] >= 4'd5)
                r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign sr_adj = dabble_adj(sr);
    assign bcd    = sr[SR_W-1:BIN_W];
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: state <= LOAD;
                LOAD: begin
                    sr    <= {{BCD_W{1'b0}}, bin};
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_SHIFT)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fnd_controller.sv
// Saturates the binary display value, converts it to BCD and scans it onto a 4-digit active-low display.
// Optional build macro FND_LZ_BLANK_EN blanks leading-zero digits (the ones digit always shows).
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int TICK_DIV = 100_000,
    parameter int MAX_VAL  = 9999
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      seg_data,
    output logic [3:0]       an,
    output logic [7:0]       seg,
    output logic [BCD_W-1:0] bcd
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        digit_sel;
    logic [13:0]       bin_sat;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_done;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [7:0]        seg_next;

    function automatic logic [13:0] sat_val(input logic [13:0] v);
        return (v > 14'(MAX_VAL)) ? 14'(MAX_VAL) : v;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign bin_sat = sat_val(seg_data);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (bin_sat),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        cur_nib   = bcd[{digit_sel, 2'b00} +: 4];
        cur_blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        // A digit is blank only when it and every higher digit are zero
        case (digit_sel)
            2'd3:    cur_blank = (bcd[15:12] == 4'd0);
            2'd2:    cur_blank = (bcd[15:8]  == 8'd0);
            2'd1:    cur_blank = (bcd[15:4]  == 12'd0);
            default: cur_blank = 1'b0;
        endcase
`endif
        seg_next = cur_blank ? SEG_BLANK : seg_decode(cur_nib);
    end

    // bcd only moves on a completed conversion, so the display never sees a partial value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_sel <= '0;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            bcd       <= '0;
        end else begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt  <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << digit_sel);
            seg <= seg_next;
            if (conv_done)
                bcd <= conv_bcd;
        end
    end

endmodule

// File: tb/tb_fnd_controller.sv
// Scoreboard bench for fnd_controller (TICK_DIV=4): expected bcd values queued by stimulus, popped by a monitor.
module tb_fnd_controller;
    import fnd_pkg::*;

    logic        clk;
    logic        reset;
    logic [13:0] seg_data;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] bcd;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    fnd_controller #(.TICK_DIV(4), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_data (seg_data),
        .an       (an),
        .seg      (seg),
        .bcd      (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FND_LZ_BLANK_EN
    localparam logic [7:0] HI_ZERO = 8'hFF;
`else
    localparam logic [7:0] HI_ZERO = 8'hC0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // bcd may only change on the edge that ends a DONE state
    task automatic monitor();
        logic        prev_done;
        logic [15:0] last_bcd;
        logic [15:0] e;
        prev_done = 1'b0;
        last_bcd  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
                last_bcd  = bcd;
            end else begin
                if (prev_done) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("bcd_done", bcd, e);
                    end
                    last_bcd = bcd;
                end else begin
                    chk("bcd_hold", bcd, last_bcd);
                end
                prev_done = dut.u_conv.done;
            end
        end
    endtask

    task automatic wait_queue(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            bound_fail(name);
            exp_q.delete();
        end
    endtask

    task automatic apply_value(input logic [13:0] v, input logic [15:0] exp);
        @(negedge clk);
        #1 seg_data = v;
        repeat (15) @(negedge clk);
        #1 exp_q.push_back(exp);
        wait_queue("bcd_latency", 20);
    endtask

    task automatic check_scan(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] es[4];
        logic [3:0] an_exp[4];
        logic [3:0] prev;
        bit ok;
        es     = '{e0, e1, e2, e3};
        an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ok     = 1'b0;
        prev   = an;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
        if (!ok) begin
            bound_fail({name, "_align"});
            return;
        end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d != 0 || c != 0) @(negedge clk);
                chk({name, "_an"}, 16'(an), 16'(an_exp[d]));
                chk({name, "_seg"}, 16'(seg), 16'(es[d]));
            end
        end
        @(negedge clk);
        chk({name, "_wrap_an"}, 16'(an), 16'(4'b1110));
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        seg_data = '0;
        fork
            monitor();
        join_none

        // reset state and first edge after release
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'(4'b1111));
        chk("rst_seg", 16'(seg), 16'(8'hFF));
        chk("rst_bcd", bcd, 16'h0000);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_an", 16'(an), 16'(4'b1110));
        chk("rel_seg", 16'(seg), 16'(8'hC0));

        apply_value(14'd1234, 16'h1234);
        check_scan("d1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        apply_value(14'd16383, 16'h9999);
        check_scan("sat16383", 8'h90, 8'h90, 8'h90, 8'h90);

        apply_value(14'd10000, 16'h9999);
        check_scan("sat10000", 8'h90, 8'h90, 8'h90, 8'h90);

        apply_value(14'd7, 16'h0007);
        check_scan("d0007", 8'hF8, HI_ZERO, HI_ZERO, HI_ZERO);

        apply_value(14'd0, 16'h0000);
        check_scan("d0000", 8'hC0, HI_ZERO, HI_ZERO, HI_ZERO);

        // input switched three clocks after LOAD: this conversion finishes 9999, the next 0000
        @(negedge clk);
        #1 seg_data = 14'd9999;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.u_conv.state == LOAD) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) bound_fail("mid_load_wait");
        repeat (3) @(negedge clk);
        #1 seg_data = 14'd0;
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0000);
        wait_queue("mid_change", 45);

        // reset during the 7th shift cycle
        @(negedge clk);
        #1 seg_data = 14'd1234;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.u_conv.state == SHIFT && dut.u_conv.cnt == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) bound_fail("mid_shift_wait");
        #1 reset = 1'b1;
        #1;
        chk("midrst_an", 16'(an), 16'(4'b1111));
        chk("midrst_seg", 16'(seg), 16'(8'hFF));
        chk("midrst_bcd", bcd, 16'h0000);
        seg_data = 14'd42;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrel_an", 16'(an), 16'(4'b1110));
        chk("midrel_seg", 16'(seg), 16'(8'hC0));
        #1 exp_q.push_back(16'h0042);
        wait_queue("post_reset_42", 34);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
